// File: rtl/pipe_hazard_ctrl.sv
// Hazard, forwarding and sequencing controller for the 5-stage core; stall/flush/forward are combinational.
// Latency: state, drain counter and stall counter update one cycle after the inputs that trigger them.
module pipe_hazard_ctrl #(
    parameter int REG_AW       = 4,
    parameter bit ZERO_REG     = 1'b1,
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hlt,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic              id_ret,
    input  logic [REG_AW-1:0] ex_rs,
    input  logic [REG_AW-1:0] ex_rt,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_regwrite,
    input  logic              ex_memread,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic              mem_regwrite,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic              wb_regwrite,
    input  logic              wb_ret,
    input  logic              branch_taken,
    output logic              stall_pc,
    output logic              stall_ifid,
    output logic [2:0]        flush,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              halted,
    output logic [1:0]        state,
    output logic [CNT_W-1:0]  stall_cnt
);

    localparam logic [1:0] ST_RUN   = 2'b00;
    localparam logic [1:0] ST_RET   = 2'b01;
    localparam logic [1:0] ST_DRAIN = 2'b10;
    localparam logic [1:0] ST_HALT  = 2'b11;

    localparam int            DW         = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LOAD = DW'(DRAIN_CYCLES - 1);

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    logic [1:0]    cur_state;
    logic [1:0]    nxt_state;
    logic          hlt_pending;
    logic          nxt_hlt_pending;
    logic [DW-1:0] drain_cnt;
    logic [DW-1:0] nxt_drain_cnt;
    logic          load_use;

    // Register 0 is a constant when ZERO_REG is set, so it can never create a dependency.
    function automatic logic reg_match(input logic [REG_AW-1:0] a,
                                       input logic [REG_AW-1:0] b,
                                       input logic              en);
        return en && (a == b) && !(ZERO_REG && (a == '0));
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [REG_AW-1:0] src);
        if (reg_match(mem_rd, src, mem_regwrite))
            return FWD_MEM;
        else if (reg_match(wb_rd, src, wb_regwrite))
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

    assign fwd_a = fwd_sel(ex_rs);
    assign fwd_b = fwd_sel(ex_rt);

    assign load_use = ex_memread && ex_regwrite &&
                      (reg_match(ex_rd, id_rs, id_rs_used) ||
                       reg_match(ex_rd, id_rt, id_rt_used));

    assign state = cur_state;

    always_ff @(posedge clk) begin
        if (rst) begin
            cur_state   <= ST_RUN;
            hlt_pending <= 1'b0;
            drain_cnt   <= '0;
        end else begin
            cur_state   <= nxt_state;
            hlt_pending <= nxt_hlt_pending;
            drain_cnt   <= nxt_drain_cnt;
        end
    end

    always_comb begin
        nxt_state       = cur_state;
        nxt_hlt_pending = hlt_pending;
        nxt_drain_cnt   = drain_cnt;
        case (cur_state)
            ST_RUN: begin
                if (hlt || hlt_pending) begin
                    nxt_state       = ST_DRAIN;
                    nxt_drain_cnt   = DRAIN_LOAD;
                    nxt_hlt_pending = 1'b0;
                end else if (id_ret && !branch_taken && !load_use) begin
                    nxt_state = ST_RET;
                end
            end
            ST_RET: begin
                // A halt seen while waiting is honoured only once the return target is loaded.
                if (wb_ret) begin
                    if (hlt || hlt_pending) begin
                        nxt_state       = ST_DRAIN;
                        nxt_drain_cnt   = DRAIN_LOAD;
                        nxt_hlt_pending = 1'b0;
                    end else begin
                        nxt_state = ST_RUN;
                    end
                end else if (hlt) begin
                    nxt_hlt_pending = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0)
                    nxt_state = ST_HALT;
                else
                    nxt_drain_cnt = drain_cnt - 1'b1;
            end
            default: begin
                nxt_state = ST_HALT;
            end
        endcase
    end

    always_comb begin
        stall_pc   = 1'b0;
        stall_ifid = 1'b0;
        flush      = 3'b000;
        halted     = 1'b0;
        case (cur_state)
            ST_RUN: begin
                // A taken branch squashes the younger instructions, so a load-use stall is moot.
                if (branch_taken) begin
                    flush = 3'b011;
                end else if (load_use) begin
                    stall_pc   = 1'b1;
                    stall_ifid = 1'b1;
                    flush      = 3'b010;
                end
            end
            ST_RET: begin
                stall_pc = !wb_ret;
                flush[0] = 1'b1;
                flush[1] = branch_taken;
            end
            ST_DRAIN: begin
                stall_pc = 1'b1;
                flush[0] = 1'b1;
                flush[1] = branch_taken;
            end
            default: begin
                halted     = 1'b1;
                stall_pc   = 1'b1;
                stall_ifid = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst)
            stall_cnt <= '0;
        else if (stall_pc && (cur_state != ST_HALT) && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle model checked every negedge plus hand-computed literals.
module tb_pipe_hazard_ctrl;

    localparam int DC = 4;

    logic clk = 1'b0;
    logic rst, hlt, id_rs_used, id_rt_used, id_ret;
    logic ex_regwrite, ex_memread, mem_regwrite, wb_regwrite, wb_ret, branch_taken;
    logic [3:0] id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;

    logic        stall_pc, stall_ifid, halted;
    logic [2:0]  flush;
    logic [1:0]  fwd_a, fwd_b, state;
    logic [15:0] stall_cnt;

    logic        s_stall_pc, s_stall_ifid, s_halted;
    logic [2:0]  s_flush;
    logic [1:0]  s_fwd_a, s_fwd_b, s_state;
    logic [1:0]  s_stall_cnt;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    // Model state: mode number, pending halt, drain cycles still to run, total stall cycles seen.
    int m_mode = 0;
    bit m_pending = 0;
    int m_left = 0;
    int m_total = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(4), .ZERO_REG(1'b1), .DRAIN_CYCLES(DC), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .hlt(hlt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_ret(id_ret), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_ret(wb_ret),
        .branch_taken(branch_taken),
        .stall_pc(stall_pc), .stall_ifid(stall_ifid), .flush(flush),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .halted(halted), .state(state), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.REG_AW(4), .ZERO_REG(1'b1), .DRAIN_CYCLES(DC), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .hlt(hlt),
        .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .id_ret(id_ret), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .wb_ret(wb_ret),
        .branch_taken(branch_taken),
        .stall_pc(s_stall_pc), .stall_ifid(s_stall_ifid), .flush(s_flush),
        .fwd_a(s_fwd_a), .fwd_b(s_fwd_b), .halted(s_halted), .state(s_state), .stall_cnt(s_stall_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
        end
    endtask

    function automatic bit hits(input logic [3:0] dst, input bit we, input logic [3:0] src, input bit used);
        return we && used && dst == src && dst != 4'd0;
    endfunction

    function automatic logic [1:0] m_fwd(input logic [3:0] src);
        if (hits(mem_rd, mem_regwrite, src, 1'b1)) return 2'b01;
        if (hits(wb_rd, wb_regwrite, src, 1'b1)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit m_load_use();
        return ex_memread && (hits(ex_rd, ex_regwrite, id_rs, id_rs_used) ||
                              hits(ex_rd, ex_regwrite, id_rt, id_rt_used));
    endfunction

    task automatic model_out(output bit spc, output bit sif, output logic [2:0] fl);
        spc = 0; sif = 0; fl = 3'b000;
        if (m_mode == 3) begin
            spc = 1; sif = 1;
        end else if (m_mode == 0) begin
            if (branch_taken) fl = 3'b011;
            else if (m_load_use()) begin spc = 1; sif = 1; fl = 3'b010; end
        end else begin
            spc = (m_mode == 2) || !wb_ret;
            fl = {1'b0, branch_taken, 1'b1};
        end
    endtask

    always @(posedge clk) begin
        bit spc, sif;
        logic [2:0] fl;
        if (rst) begin
            m_mode = 0; m_pending = 0; m_left = 0; m_total = 0;
        end else begin
            model_out(spc, sif, fl);
            if (spc && m_mode != 3) m_total++;
            if (m_mode == 0) begin
                if (hlt || m_pending) begin m_mode = 2; m_left = DC; m_pending = 0; end
                else if (id_ret && !branch_taken && !m_load_use()) m_mode = 1;
            end else if (m_mode == 1) begin
                if (wb_ret) begin
                    if (hlt || m_pending) begin m_mode = 2; m_left = DC; m_pending = 0; end
                    else m_mode = 0;
                end else if (hlt) m_pending = 1;
            end else if (m_mode == 2) begin
                m_left--;
                if (m_left == 0) m_mode = 3;
            end
        end
    end

    always @(negedge clk) begin
        bit spc, sif;
        logic [2:0] fl;
        if (chk_en) begin
            model_out(spc, sif, fl);
            chk("m_state", 32'(state), 32'(m_mode));
            chk("m_halted", 32'(halted), 32'(m_mode == 3));
            chk("m_stall_pc", 32'(stall_pc), 32'(spc));
            chk("m_stall_ifid", 32'(stall_ifid), 32'(sif));
            chk("m_flush", 32'(flush), 32'(fl));
            chk("m_fwd_a", 32'(fwd_a), 32'(m_fwd(ex_rs)));
            chk("m_fwd_b", 32'(fwd_b), 32'(m_fwd(ex_rt)));
            chk("m_stall_cnt", 32'(stall_cnt), (m_total > 65535) ? 32'd65535 : 32'(m_total));
            chk("m_sat_cnt", 32'(s_stall_cnt), (m_total > 3) ? 32'd3 : 32'(m_total));
            chk("m_sat_state", 32'(s_state), 32'(m_mode));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        hlt = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0; id_ret = 0;
        ex_rs = 0; ex_rt = 0; ex_rd = 0; ex_regwrite = 0; ex_memread = 0;
        mem_rd = 0; mem_regwrite = 0; wb_rd = 0; wb_regwrite = 0; wb_ret = 0; branch_taken = 0;
    endtask

    task automatic set_load_use();
        ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd3; id_rs = 4'd3; id_rs_used = 1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1;
        clear_inputs();
        @(posedge clk);
        chk_en = 1;
        tick();
        rst = 0;
        settle();
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_stall_pc", 32'(stall_pc), 32'd0);

        tick(); set_load_use(); settle();
        chk("lu_stall_pc", 32'(stall_pc), 32'd1);
        chk("lu_stall_ifid", 32'(stall_ifid), 32'd1);
        chk("lu_flush", 32'(flush), 32'b010);
        tick(); clear_inputs(); settle();
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        chk("lu_released", 32'(stall_pc), 32'd0);

        tick(); ex_memread = 1; ex_regwrite = 1; ex_rd = 4'd6; id_rt = 4'd6; id_rt_used = 1; settle();
        chk("lu_rt", 32'(stall_pc), 32'd1);
        tick(); ex_rd = 4'd0; id_rt = 4'd0; id_rs = 4'd0; id_rs_used = 1; settle();
        chk("lu_zero", 32'(stall_pc), 32'd0);
        tick(); clear_inputs();

        ex_rs = 5; ex_rt = 5; mem_rd = 5; wb_rd = 5; mem_regwrite = 1; wb_regwrite = 1; settle();
        chk("fwd_mem_pri", 32'(fwd_a), 32'b01);
        chk("fwd_b_mem", 32'(fwd_b), 32'b01);
        tick(); mem_regwrite = 0; settle();
        chk("fwd_wb", 32'(fwd_a), 32'b10);
        tick(); mem_regwrite = 1; ex_rs = 0; ex_rt = 0; mem_rd = 0; wb_rd = 0; settle();
        chk("fwd_zero", 32'(fwd_a), 32'b00);
        tick(); ex_rs = 2; ex_rt = 7; mem_rd = 7; mem_regwrite = 0; wb_rd = 7; settle();
        chk("fwd_b_wb", 32'(fwd_b), 32'b10);
        chk("fwd_a_none", 32'(fwd_a), 32'b00);
        tick(); clear_inputs();

        set_load_use(); branch_taken = 1; settle();
        chk("br_stall_pc", 32'(stall_pc), 32'd0);
        chk("br_stall_ifid", 32'(stall_ifid), 32'd0);
        chk("br_flush", 32'(flush), 32'b011);
        tick(); clear_inputs();

        id_ret = 1; settle();
        chk("ret_issue_state", 32'(state), 32'd0);
        tick(); id_ret = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("ret_wait_state", 32'(state), 32'd1);
            chk("ret_wait_stall", 32'(stall_pc), 32'd1);
            chk("ret_wait_flush", 32'(flush), 32'b001);
            tick();
        end
        wb_ret = 1; settle();
        chk("ret_exit_stall", 32'(stall_pc), 32'd0);
        tick(); wb_ret = 0; settle();
        chk("ret_back_run", 32'(state), 32'd0);
        chk("ret_cnt", 32'(stall_cnt), 32'd5);
        chk("sat_cnt", 32'(s_stall_cnt), 32'd3);

        tick(); hlt = 1; settle();
        chk("hlt_first_run", 32'(state), 32'd0);
        tick();
        for (int i = 0; i < DC; i++) begin
            branch_taken = (i == 1);
            settle();
            chk("drain_state", 32'(state), 32'd2);
            chk("drain_stall", 32'(stall_pc), 32'd1);
            chk("drain_flush", 32'(flush), (i == 1) ? 32'b011 : 32'b001);
            tick();
        end
        branch_taken = 0; settle();
        chk("halt_state", 32'(state), 32'd3);
        chk("halt_flag", 32'(halted), 32'd1);
        chk("halt_flush", 32'(flush), 32'd0);
        chk("halt_ifid", 32'(stall_ifid), 32'd1);
        hlt = 0; tick(); tick(); settle();
        chk("halt_sticky", 32'(halted), 32'd1);
        chk("halt_cnt", 32'(stall_cnt), 32'd9);

        rst = 1; tick(); rst = 0; settle();
        chk("rst2_state", 32'(state), 32'd0);
        chk("rst2_halted", 32'(halted), 32'd0);
        chk("rst2_cnt", 32'(stall_cnt), 32'd0);

        tick(); id_ret = 1; tick(); id_ret = 0; settle();
        chk("hr_wait", 32'(state), 32'd1);
        hlt = 1; tick(); hlt = 0; settle();
        chk("hr_still_wait", 32'(state), 32'd1);
        tick(); wb_ret = 1; settle();
        chk("hr_exit_wait", 32'(state), 32'd1);
        tick(); wb_ret = 0; settle();
        chk("hr_drain", 32'(state), 32'd2);
        for (int i = 0; i < DC - 1; i++) begin
            tick(); settle();
            chk("hr_drain_hold", 32'(state), 32'd2);
        end
        tick(); settle();
        chk("hr_halted", 32'(state), 32'd3);
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
